matinv_sequencer: RTL

- Control sequencer between the software register file and the HLS matrix-inversion core.
- Launches the core over its ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_idle) and enforces a software-programmed cycle timeout.
- Aborts a hung core by pulsing its reset.
- Locks the PS BRAM ports of the input and output matrix RAMs while a run is in flight, and reports status, counters and an interrupt back to the register file.

---
 rtl/matinv_pkg.sv | 15 +
 rtl/matinv_sequencer_sat_counter.sv | 29 ++
 rtl/matinv_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/matinv_pkg.sv
// Shared types and defaults for the matrix-inversion control sequencer.
package matinv_pkg;

    localparam int MATINV_CNT_W        = 32;
    localparam int MATINV_ABORT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/matinv_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count register: clear has priority, increment stops at all-ones
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_clr) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/matinv_sequencer.sv
// Drives the HLS matrix-inversion core over ap_ctrl_hs, enforces a run timeout,
// aborts a hung core through its reset and locks the PS BRAM ports while busy.
import matinv_pkg::*;

module matinv_sequencer #(
    parameter int CNT_W        = MATINV_CNT_W,
    parameter int RUN_W        = 16,
    parameter int BLK_W        = 16,
    parameter int ABORT_CYCLES = MATINV_ABORT_CYCLES
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             ctrl_start,
    input  logic             ctrl_abort,
    input  logic             ctrl_irq_clr,
    input  logic             ctrl_irq_en,
    input  logic [CNT_W-1:0] timeout_cycles,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_idle,
    output logic             core_rst_n,
    input  logic [1:0]       ps_en_in,
    input  logic [3:0]       ps_we0_in,
    input  logic [3:0]       ps_we1_in,
    output logic [1:0]       ps_en_out,
    output logic [3:0]       ps_we0_out,
    output logic [3:0]       ps_we1_out,
    output logic             busy,
    output logic             done_sticky,
    output logic             timeout_err,
    output logic             start_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [RUN_W-1:0] run_count,
    output logic [BLK_W-1:0] blocked_count,
    output logic             irq
);

    localparam int AB_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [AB_W-1:0]  r_abort_cnt;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_ap_start;
    logic             r_busy;
    logic             r_core_rst_n;
    logic             r_done_sticky;
    logic             r_timeout_err;
    logic             r_start_err;
    logic             r_irq;
    logic             w_start_ok;
    logic             w_start_err_set;
    logic             w_timeout_set;
    logic             w_timeout_hit;
    logic             w_in_run;

    assign w_in_run      = (r_state == ST_START) || (r_state == ST_RUN);
    assign w_timeout_hit = (timeout_cycles != {CNT_W{1'b0}}) &&
                           (r_cycle_count == (timeout_cycles - CNT_W'(1)));

    // Next-state decode; abort beats done, done beats timeout
    always_comb begin
        w_next_state    = r_state;
        w_start_ok      = 1'b0;
        w_start_err_set = 1'b0;
        w_timeout_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_abort) begin
                    w_next_state = ST_ABORT;
                end else if (ctrl_start && ap_idle) begin
                    w_next_state = ST_START;
                    w_start_ok   = 1'b1;
                end else if (ctrl_start) begin
                    w_start_err_set = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (ctrl_abort) begin
                    w_next_state = ST_ABORT;
                end else if (ap_ready && ap_done) begin
                    w_next_state = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_next_state  = ST_ABORT;
                    w_timeout_set = 1'b1;
                end else if (ap_ready) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_RUN: begin
                if (ctrl_abort) begin
                    w_next_state = ST_ABORT;
                end else if (ap_done) begin
                    w_next_state = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_next_state  = ST_ABORT;
                    w_timeout_set = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            ST_ABORT: begin
                if (r_abort_cnt == {AB_W{1'b0}}) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ABORT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register plus registered copies of the state-derived outputs
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state      <= ST_IDLE;
            r_ap_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ap_start   <= (w_next_state == ST_START);
            r_busy       <= (w_next_state != ST_IDLE);
            r_core_rst_n <= (w_next_state != ST_ABORT);
        end
    end

    // Abort hold counter: loaded on entry so the core reset lasts ABORT_CYCLES
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_abort_cnt <= {AB_W{1'b0}};
        end else if ((w_next_state == ST_ABORT) && (r_state != ST_ABORT)) begin
            r_abort_cnt <= AB_W'(ABORT_CYCLES - 1);
        end else if ((r_state == ST_ABORT) && (r_abort_cnt != {AB_W{1'b0}})) begin
            r_abort_cnt <= r_abort_cnt - AB_W'(1);
        end else begin
            r_abort_cnt <= r_abort_cnt;
        end
    end

    // Run cycle counter, frozen outside START/RUN so software can read it after
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_cycle_count <= {CNT_W{1'b0}};
        end else if (w_start_ok) begin
            r_cycle_count <= {CNT_W{1'b0}};
        end else if (w_in_run) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end else begin
            r_cycle_count <= r_cycle_count;
        end
    end

    // Status stickies: a set in the same cycle as a clear wins
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_done_sticky <= 1'b0;
            r_timeout_err <= 1'b0;
            r_start_err   <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (r_state == ST_DONE) begin
                r_done_sticky <= 1'b1;
            end else if (ctrl_irq_clr || w_start_ok) begin
                r_done_sticky <= 1'b0;
            end else begin
                r_done_sticky <= r_done_sticky;
            end
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (ctrl_irq_clr || w_start_ok) begin
                r_timeout_err <= 1'b0;
            end else begin
                r_timeout_err <= r_timeout_err;
            end
            if (w_start_err_set) begin
                r_start_err <= 1'b1;
            end else if (ctrl_irq_clr) begin
                r_start_err <= 1'b0;
            end else begin
                r_start_err <= r_start_err;
            end
            r_irq <= ctrl_irq_en & (r_done_sticky | r_timeout_err);
        end
    end

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .i_clk   (axi_aclk),
        .i_rst_n (axi_aresetn),
        .i_clr   (1'b0),
        .i_inc   (r_state == ST_DONE),
        .o_count (run_count)
    );

    sat_counter #(.W(BLK_W)) u_blk_cnt (
        .i_clk   (axi_aclk),
        .i_rst_n (axi_aresetn),
        .i_clr   (1'b0),
        .i_inc   (r_busy & (|ps_en_in)),
        .o_count (blocked_count)
    );

    // PS ports pass straight through when idle so software access has no latency
    assign ps_en_out   = r_busy ? 2'b00 : ps_en_in;
    assign ps_we0_out  = r_busy ? 4'h0  : ps_we0_in;
    assign ps_we1_out  = r_busy ? 4'h0  : ps_we1_in;

    assign ap_start    = r_ap_start;
    assign busy        = r_busy;
    assign core_rst_n  = r_core_rst_n;
    assign done_sticky = r_done_sticky;
    assign timeout_err = r_timeout_err;
    assign start_err   = r_start_err;
    assign cycle_count = r_cycle_count;
    assign irq         = r_irq;

endmodule
